// File: rtl/txpippm_step_sequencer.sv
// txpippm_step_sequencer: turns a signed step command into a train of wide, evenly spaced
// pulses with a stable select and step-size word for the TX phase-interpolator PPM controllers.
module txpippm_step_sequencer #(
    parameter int CHANNEL_COUNT  = 10,
    parameter int COUNT_WIDTH    = 16,
    parameter int INTERVAL_WIDTH = 16,
    parameter int PULSE_WIDTH    = 8
) (
    input  logic                     clk_in,
    input  logic                     reset_in,
    input  logic                     cmd_valid_in,
    output logic                     cmd_ready_out,
    input  logic [CHANNEL_COUNT-1:0] cmd_sel_in,
    input  logic [COUNT_WIDTH-1:0]   cmd_steps_in,
    input  logic [3:0]               cmd_magnitude_in,
    input  logic [INTERVAL_WIDTH-1:0] cmd_interval_in,
    input  logic                     abort_in,
    output logic [CHANNEL_COUNT-1:0] sel_out,
    output logic                     pulse_out,
    output logic [4:0]               stepsize_out,
    output logic                     busy_out,
    output logic                     done_out,
    output logic [COUNT_WIDTH-1:0]   steps_remaining_out,
    output logic [1:0]               state_out
);
    localparam int PCW = $clog2(PULSE_WIDTH) + 1;
    localparam int CW  = INTERVAL_WIDTH > PCW ? INTERVAL_WIDTH : PCW;

    // Encoding changes one bit per normal transition, so pulse_out decoded from state is glitch-free.
    typedef enum logic [1:0] {IDLE = 2'b00, SETUP = 2'b01, HIGH = 2'b11, LOW = 2'b10} state_t;

    state_t state, next;
    logic [CW-1:0] cnt, low_len;
    logic [COUNT_WIDTH-1:0] remaining;
    logic abort_held;

    assign cmd_ready_out       = state == IDLE;
    assign busy_out            = state != IDLE;
    assign pulse_out           = state == HIGH;
    assign state_out           = state;
    assign steps_remaining_out = remaining;

    always_comb begin
        next = state;
        case (state)
            IDLE:  next = cmd_valid_in ? SETUP : IDLE;
            SETUP: next = (abort_in || remaining == '0 || stepsize_out[3:0] == 4'd0) ? IDLE : HIGH;
            HIGH:  next = cnt != '0 ? HIGH : (abort_in || abort_held) ? IDLE : LOW;
            LOW:   next = abort_in ? IDLE : cnt != '0 ? LOW : remaining != '0 ? HIGH : IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state        <= IDLE;
            cnt          <= '0;
            low_len      <= '0;
            remaining    <= '0;
            abort_held   <= 1'b0;
            sel_out      <= '0;
            stepsize_out <= '0;
            done_out     <= 1'b0;
        end else begin
            state      <= next;
            done_out   <= state != IDLE && next == IDLE;
            // An abort seen mid-pulse is remembered so the pulse still completes its full width.
            abort_held <= state == HIGH && next == HIGH && (abort_held || abort_in);
            if (state == IDLE && cmd_valid_in) begin
                sel_out      <= cmd_sel_in;
                stepsize_out <= {~cmd_steps_in[COUNT_WIDTH-1], cmd_magnitude_in};
                remaining    <= cmd_steps_in[COUNT_WIDTH-1] ? -cmd_steps_in : cmd_steps_in;
                low_len      <= CW'(cmd_interval_in) < CW'(PULSE_WIDTH) ? CW'(PULSE_WIDTH)
                                                                         : CW'(cmd_interval_in);
            end
            if (state == HIGH && cnt == '0)
                remaining <= remaining - COUNT_WIDTH'(1);
            if (next == HIGH && state != HIGH)
                cnt <= CW'(PULSE_WIDTH - 1);
            else if (next == LOW && state == HIGH)
                cnt <= low_len - CW'(1);
            else if (cnt != '0)
                cnt <= cnt - CW'(1);
        end
    end
endmodule

// File: tb/tb_txpippm_step_sequencer.sv
// tb_txpippm_step_sequencer: directed self-checking bench for the PPM step sequencer.
module tb_txpippm_step_sequencer;
    logic        clk_in = 1'b0;
    logic        reset_in = 1'b0;
    logic        cmd_valid_in = 1'b0;
    logic        cmd_ready_out;
    logic [9:0]  cmd_sel_in = '0;
    logic [15:0] cmd_steps_in = '0;
    logic [3:0]  cmd_magnitude_in = '0;
    logic [15:0] cmd_interval_in = '0;
    logic        abort_in = 1'b0;
    logic [9:0]  sel_out;
    logic        pulse_out;
    logic [4:0]  stepsize_out;
    logic        busy_out;
    logic        done_out;
    logic [15:0] steps_remaining_out;
    logic [1:0]  state_out;

    int vectors = 0;
    int errors = 0;

    txpippm_step_sequencer dut (
        .clk_in(clk_in), .reset_in(reset_in), .cmd_valid_in(cmd_valid_in),
        .cmd_ready_out(cmd_ready_out), .cmd_sel_in(cmd_sel_in), .cmd_steps_in(cmd_steps_in),
        .cmd_magnitude_in(cmd_magnitude_in), .cmd_interval_in(cmd_interval_in),
        .abort_in(abort_in), .sel_out(sel_out), .pulse_out(pulse_out),
        .stepsize_out(stepsize_out), .busy_out(busy_out), .done_out(done_out),
        .steps_remaining_out(steps_remaining_out), .state_out(state_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cmd(input logic [9:0] sel, input logic [15:0] steps, input logic [3:0] mag,
                       input logic [15:0] interval);
        cmd_sel_in       = sel;
        cmd_steps_in     = steps;
        cmd_magnitude_in = mag;
        cmd_interval_in  = interval;
        cmd_valid_in     = 1'b1;
    endtask

    initial begin
        #2 reset_in = 1'b1;
        step();
        step();
        check("rst_pulse", pulse_out, 0);
        check("rst_sel", sel_out, 0);
        check("rst_stepsize", stepsize_out, 0);
        check("rst_busy", busy_out, 0);
        check("rst_done", done_out, 0);
        check("rst_rem", steps_remaining_out, 0);
        check("rst_state", state_out, 0);
        check("rst_ready", cmd_ready_out, 1);
        reset_in = 1'b0;
        step();

        // +3 steps, magnitude 4, interval 10
        cmd(10'h003, 16'd3, 4'd4, 16'd10);
        check("t1_ready", cmd_ready_out, 1);
        step();
        cmd_valid_in = 1'b0;
        for (int c = 1; c <= 58; c++) begin
            if (c == 1) begin
                check("t1_stepsize", stepsize_out, 5'b10100);
                check("t1_sel", sel_out, 10'h003);
                check("t1_setup", state_out, 2'b01);
            end
            check($sformatf("t1_pulse_c%0d", c), pulse_out,
                  (c >= 2 && c <= 9) || (c >= 20 && c <= 27) || (c >= 38 && c <= 45));
            check($sformatf("t1_done_c%0d", c), done_out, c == 56);
            check($sformatf("t1_rem_c%0d", c), steps_remaining_out,
                  c < 10 ? 3 : c < 28 ? 2 : c < 46 ? 1 : 0);
            step();
        end

        // -2 steps, magnitude 1, interval 3 clamped to 8
        cmd(10'h005, -16'sd2, 4'd1, 16'd3);
        step();
        cmd_valid_in = 1'b0;
        for (int c = 1; c <= 36; c++) begin
            if (c == 1) begin
                check("t2_stepsize", stepsize_out, 5'b00001);
                check("t2_sel", sel_out, 10'h005);
            end
            check($sformatf("t2_pulse_c%0d", c), pulse_out,
                  (c >= 2 && c <= 9) || (c >= 18 && c <= 25));
            check($sformatf("t2_done_c%0d", c), done_out, c == 34);
            check($sformatf("t2_rem_c%0d", c), steps_remaining_out, c < 10 ? 2 : c < 26 ? 1 : 0);
            step();
        end

        // zero steps
        cmd(10'h001, 16'd0, 4'd5, 16'd10);
        step();
        cmd_valid_in = 1'b0;
        check("t3a_setup", state_out, 2'b01);
        check("t3a_pulse1", pulse_out, 0);
        step();
        check("t3a_done", done_out, 1);
        check("t3a_idle", state_out, 0);
        check("t3a_pulse2", pulse_out, 0);
        step();
        check("t3a_done_off", done_out, 0);

        // zero magnitude
        cmd(10'h001, 16'd4, 4'd0, 16'd10);
        step();
        cmd_valid_in = 1'b0;
        check("t3b_setup", state_out, 2'b01);
        check("t3b_rem", steps_remaining_out, 4);
        step();
        check("t3b_done", done_out, 1);
        check("t3b_pulse", pulse_out, 0);
        check("t3b_rem_kept", steps_remaining_out, 4);
        step();

        // most-negative step count
        cmd(10'h001, 16'h8000, 4'd0, 16'd10);
        step();
        cmd_valid_in = 1'b0;
        check("t3c_rem", steps_remaining_out, 32768);
        check("t3c_stepsize", stepsize_out, 5'b00000);
        step();
        check("t3c_done", done_out, 1);
        step();

        // abort during first LOW of a 5-step sequence
        cmd(10'h001, 16'd5, 4'd2, 16'd10);
        step();
        cmd_valid_in = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            check($sformatf("t4a_pulse_c%0d", c), pulse_out, c >= 2 && c <= 9);
            if (c == 12) abort_in = 1'b1;
            step();
        end
        abort_in = 1'b0;
        check("t4a_idle", state_out, 0);
        check("t4a_done", done_out, 1);
        check("t4a_rem", steps_remaining_out, 4);
        check("t4a_pulse", pulse_out, 0);
        step();
        check("t4a_done_off", done_out, 0);

        // abort on the third HIGH cycle: pulse completes, no LOW
        cmd(10'h001, 16'd5, 4'd2, 16'd10);
        step();
        cmd_valid_in = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            check($sformatf("t4b_pulse_c%0d", c), pulse_out, c >= 2 && c <= 9);
            check($sformatf("t4b_done_c%0d", c), done_out, c == 10);
            abort_in = c == 4;
            step();
        end
        abort_in = 1'b0;
        step();
        check("t4b_idle", state_out, 0);
        check("t4b_rem", steps_remaining_out, 4);

        // valid held through busy, back-to-back accept in done cycle, then reset mid-HIGH
        cmd(10'h3FF, 16'd1, 4'd1, 16'd8);
        step();
        for (int c = 1; c <= 18; c++) begin
            check($sformatf("t5_sel_c%0d", c), sel_out, 10'h3FF);
            check($sformatf("t5_rem_c%0d", c), steps_remaining_out, c < 10 ? 1 : 0);
            check($sformatf("t5_done_c%0d", c), done_out, c == 18);
            check($sformatf("t5_ready_c%0d", c), cmd_ready_out, c == 18);
            check($sformatf("t5_pulse_c%0d", c), pulse_out, c >= 2 && c <= 9);
            if (c == 5) begin
                cmd_sel_in   = 10'h2AA;
                cmd_steps_in = 16'd3;
            end
            step();
        end
        cmd_valid_in = 1'b0;
        check("t5_b2b_setup", state_out, 2'b01);
        check("t5_b2b_sel", sel_out, 10'h2AA);
        check("t5_b2b_rem", steps_remaining_out, 3);
        step();
        step();
        check("t5_high", pulse_out, 1);
        reset_in = 1'b1;
        #1;
        check("t5_rst_pulse", pulse_out, 0);
        check("t5_rst_state", state_out, 0);
        check("t5_rst_sel", sel_out, 0);
        check("t5_rst_stepsize", stepsize_out, 0);
        check("t5_rst_rem", steps_remaining_out, 0);
        check("t5_rst_done", done_out, 0);
        check("t5_rst_busy", busy_out, 0);
        step();
        check("t5_rst_done2", done_out, 0);
        reset_in = 1'b0;
        step();
        step();
        check("t5_post_done", done_out, 0);
        check("t5_post_state", state_out, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
